// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style acknowledge sequencer.
// Holds the FSM encoding, the CALL opcode and the rotating find-first.
package pic_pkg;

  typedef enum logic [2:0] {
    PIC_IDLE,
    PIC_ACK1,
    PIC_ACK2,
    PIC_ACK3,
    PIC_POLL
  } pic_ack_state_t;

  localparam logic [7:0] PIC_CALL_OPCODE = 8'hCD;
  localparam int         PIC_MAX_IRQ     = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pic_find_t;

  // Scan starts one past ptr, so ptr itself is the lowest priority.
  function automatic pic_find_t pic_rot_priority(
    input logic [31:0] vec,
    input logic [4:0]  ptr,
    input int          n
  );
    pic_find_t  r;
    logic [4:0] ch;
    r = '0;
    for (int k = 1; k <= PIC_MAX_IRQ; k++) begin
      ch = (ptr + 5'(k)) & 5'(n - 1);
      if (k <= n && !r.found && vec[ch]) begin
        r.found = 1'b1;
        r.idx   = ch;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority find-first over a request or in-service vector.
// Index is only meaningful while valid is high.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [ID_W-1:0]    rot_ptr,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  pic_find_t f;

  always_comb begin
    f     = pic_rot_priority(32'(vec), 5'(rot_ptr), NUM_IRQ);
    valid = f.found;
    index = ID_W'(f.idx);
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// Clocked 8259A priority, in-service and INTA sequencing block.
// Define PIC_AUTO_ROTATE_EN to rotate priority on every EOI.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ  = 8,
  parameter  int VECTOR_W = 8,
  localparam int ID_W     = $clog2(NUM_IRQ)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                edge_mode,
  input  logic [NUM_IRQ-1:0]  mask,
  input  logic [VECTOR_W-1:0] vector_base,
  input  logic                mode_8086,
  input  logic                auto_eoi,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [ID_W-1:0]     eoi_level,
  input  logic                poll_req,
  input  logic                inta_n,
  output logic                int_out,
  output logic                data_valid,
  output logic [VECTOR_W-1:0] data_out,
  output logic [NUM_IRQ-1:0]  irr,
  output logic [NUM_IRQ-1:0]  isr
);

  pic_ack_state_t      state, state_d;
  logic                inta_prev;
  logic [NUM_IRQ-1:0]  irq_prev;
  logic [ID_W-1:0]     ack_id, ack_id_d;
  logic                ack_real, ack_real_d;
  logic                latch, ack_done;
  logic                inta_fall, inta_rise;
  logic                win_v, top_v;
  logic [ID_W-1:0]     win_id, top_id;
  logic [ID_W-1:0]     win_rank, top_rank;
  logic                int_d, dv_d;
  logic [VECTOR_W-1:0] do_d;
  logic [NUM_IRQ-1:0]  irr_d, isr_d, ack_clr;

`ifdef PIC_AUTO_ROTATE_EN
  logic [ID_W-1:0] rot_ptr, rot_lvl;
  logic            rot_set;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rot_ptr <= ID_W'(NUM_IRQ - 1);
    else if (rot_set) rot_ptr <= rot_lvl;
  end
`else
  logic [ID_W-1:0] rot_ptr;
  assign rot_ptr = ID_W'(NUM_IRQ - 1);
`endif

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_win (
    .vec     (irr & ~mask),
    .rot_ptr (rot_ptr),
    .valid   (win_v),
    .index   (win_id)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_top (
    .vec     (isr),
    .rot_ptr (rot_ptr),
    .valid   (top_v),
    .index   (top_id)
  );

  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;

  // Rank 0 is the highest-priority slot after rot_ptr.
  assign win_rank = win_id - rot_ptr - ID_W'(1);
  assign top_rank = top_id - rot_ptr - ID_W'(1);
  assign int_d    = win_v & (~top_v | (win_rank < top_rank));

  always_comb begin
    state_d = state;
    latch   = 1'b0;
    unique case (state)
      PIC_IDLE: begin
        if (inta_fall) begin
          state_d = PIC_ACK1;
          latch   = 1'b1;
        end else if (poll_req) begin
          state_d = PIC_POLL;
          latch   = 1'b1;
        end
      end
      PIC_ACK1: if (inta_rise) state_d = PIC_ACK2;
      PIC_ACK2: begin
        if (inta_rise)
          state_d = mode_8086 ? PIC_IDLE : PIC_ACK3;
      end
      PIC_ACK3: if (inta_rise) state_d = PIC_IDLE;
      PIC_POLL: state_d = PIC_IDLE;
      default:  state_d = PIC_IDLE;
    endcase
  end

  assign ack_done = inta_rise &
    ((state == PIC_ACK2 & mode_8086) | state == PIC_ACK3);

  always_comb begin
    ack_id_d   = ack_id;
    ack_real_d = ack_real;
    if (latch) begin
      ack_id_d   = win_v ? win_id : '1;
      ack_real_d = win_v;
    end
  end

  // EOI clears are applied before the acknowledge set.
  always_comb begin
    isr_d = isr;
`ifdef PIC_AUTO_ROTATE_EN
    rot_set = 1'b0;
    rot_lvl = rot_ptr;
`endif
    if (ack_done && auto_eoi && ack_real) begin
      isr_d[ack_id] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
      rot_set = 1'b1;
      rot_lvl = ack_id;
`endif
    end
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (isr[eoi_level]) begin
          isr_d[eoi_level] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
          rot_set = 1'b1;
          rot_lvl = eoi_level;
`endif
        end
      end else if (top_v) begin
        isr_d[top_id] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
        rot_set = 1'b1;
        rot_lvl = top_id;
`endif
      end
    end
    if (latch && win_v) isr_d[win_id] = 1'b1;
  end

  always_comb begin
    ack_clr = '0;
    if (latch && win_v) ack_clr = NUM_IRQ'(1) << win_id;
    if (edge_mode)
      irr_d = ((irr & ~ack_clr) | (irq & ~irq_prev)) & irq;
    else
      irr_d = irq;
  end

  always_comb begin
    dv_d = 1'b0;
    do_d = '0;
    unique case (state_d)
      PIC_ACK1: begin
        if (!inta_n && !mode_8086) begin
          dv_d = 1'b1;
          do_d = VECTOR_W'(PIC_CALL_OPCODE);
        end
      end
      PIC_ACK2: begin
        if (!inta_n) begin
          dv_d = 1'b1;
          do_d = {vector_base[VECTOR_W-1:ID_W], ack_id_d};
        end
      end
      PIC_ACK3: begin
        if (!inta_n) begin
          dv_d = 1'b1;
          do_d = vector_base;
        end
      end
      PIC_POLL: begin
        dv_d = 1'b1;
        if (ack_real_d) begin
          do_d[VECTOR_W-1] = 1'b1;
          do_d[ID_W-1:0]   = ack_id_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PIC_IDLE;
      inta_prev  <= 1'b1;
      irq_prev   <= '0;
      ack_id     <= '0;
      ack_real   <= 1'b0;
      int_out    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      irr        <= '0;
      isr        <= '0;
    end else begin
      state      <= state_d;
      inta_prev  <= inta_n;
      irq_prev   <= irq;
      ack_id     <= ack_id_d;
      ack_real   <= ack_real_d;
      int_out    <= int_d;
      data_valid <= dv_d;
      data_out   <= do_d;
      irr        <= irr_d;
      isr        <= isr_d;
    end
  end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench for pic_ack_sequencer: cycle table plus
// hand sequences for edge mode, auto-EOI and async reset.
module tb_pic_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq = '0;
  logic       edge_mode = 1'b0;
  logic [7:0] mask = '0;
  logic [7:0] vector_base = 8'h40;
  logic       mode_8086 = 1'b1;
  logic       auto_eoi = 1'b0;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = '0;
  logic       poll_req = 1'b0;
  logic       inta_n = 1'b1;
  logic       int_out, data_valid;
  logic [7:0] data_out, irr, isr;

  pic_ack_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .irq          (irq),
    .edge_mode    (edge_mode),
    .mask         (mask),
    .vector_base  (vector_base),
    .mode_8086    (mode_8086),
    .auto_eoi     (auto_eoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .poll_req     (poll_req),
    .inta_n       (inta_n),
    .int_out      (int_out),
    .data_valid   (data_valid),
    .data_out     (data_out),
    .irr          (irr),
    .isr          (isr)
  );

  always #5 clock = ~clock;

  // ctl = {inta_n, poll_req, eoi_valid, eoi_specific}
  typedef struct {
    logic [7:0] irq;
    logic [3:0] ctl;
    logic [2:0] lvl;
    logic       m86;
    logic       e_int;
    logic       e_dv;
    logic [7:0] e_do;
    logic [7:0] e_irr;
    logic [7:0] e_isr;
  } vec_t;

  vec_t tv[33];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string t,
                         input logic i, input logic v,
                         input logic [7:0] d,
                         input logic [7:0] r,
                         input logic [7:0] s);
    chk({t, ".int_out"}, 32'(int_out), 32'(i));
    chk({t, ".data_valid"}, 32'(data_valid), 32'(v));
    chk({t, ".data_out"}, 32'(data_out), 32'(d));
    chk({t, ".irr"}, 32'(irr), 32'(r));
    chk({t, ".isr"}, 32'(isr), 32'(s));
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    tv[0]  = '{8'h24, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h24, 8'h00};
    tv[1]  = '{8'h24, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h24, 8'h00};
    tv[2]  = '{8'h24, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h24, 8'h04};
    tv[3]  = '{8'h24, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h24, 8'h04};
    tv[4]  = '{8'h24, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 8'h42, 8'h24, 8'h04};
    tv[5]  = '{8'h24, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h24, 8'h04};
    tv[6]  = '{8'h02, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h04};
    tv[7]  = '{8'h02, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 8'h04};
    tv[8]  = '{8'h40, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 8'h04};
    tv[9]  = '{8'h40, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h04};
    tv[10] = '{8'h40, 4'b1010, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00};
    tv[11] = '{8'h40, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 8'h00};
    tv[12] = '{8'h20, 4'b1000, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00};
    tv[13] = '{8'h20, 4'b1000, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00};
    tv[14] = '{8'h20, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1, 8'hCD, 8'h20, 8'h20};
    tv[15] = '{8'h20, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20};
    tv[16] = '{8'h20, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 8'h45, 8'h20, 8'h20};
    tv[17] = '{8'h20, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20};
    tv[18] = '{8'h20, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 8'h40, 8'h20, 8'h20};
    tv[19] = '{8'h20, 4'b1000, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20};
    tv[20] = '{8'h00, 4'b1011, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[21] = '{8'h00, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[22] = '{8'h00, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[23] = '{8'h00, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[24] = '{8'h00, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 8'h47, 8'h00, 8'h00};
    tv[25] = '{8'h00, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[26] = '{8'h10, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00};
    tv[27] = '{8'h10, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 8'h00};
    tv[28] = '{8'h10, 4'b1100, 3'd0, 1'b1, 1'b1, 1'b1, 8'h84, 8'h10, 8'h10};
    tv[29] = '{8'h10, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h10};
    tv[30] = '{8'h00, 4'b1010, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tv[31] = '{8'h00, 4'b1100, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    tv[32] = '{8'h00, 4'b1000, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};

    repeat (2) tick;
    chk_out("reset", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      irq = tv[i].irq;
      {inta_n, poll_req, eoi_valid, eoi_specific} = tv[i].ctl;
      eoi_level = tv[i].lvl;
      mode_8086 = tv[i].m86;
      tick;
      chk_out($sformatf("row%0d", i), tv[i].e_int, tv[i].e_dv,
              tv[i].e_do, tv[i].e_irr, tv[i].e_isr);
    end
    {inta_n, poll_req, eoi_valid, eoi_specific} = 4'b1000;

    // Edge mode with IR0 masked, auto-EOI on the 8086 sequence.
    edge_mode = 1'b1;
    auto_eoi  = 1'b1;
    mode_8086 = 1'b1;
    mask      = 8'h01;
    irq       = 8'h03;
    tick;
    chk("edge.irr_set", 32'(irr), 32'h03);
    tick;
    chk("edge.int_out", 32'(int_out), 32'h1);
    inta_n = 1'b0;
    tick;
    chk("edge.isr_set", 32'(isr), 32'h02);
    chk("edge.irr_ack_clr", 32'(irr), 32'h01);
    inta_n = 1'b1;
    tick;
    inta_n = 1'b0;
    tick;
    chk("edge.vec", 32'(data_out), 32'h41);
    inta_n = 1'b1;
    tick;
    chk("aeoi.isr_clr", 32'(isr), 32'h00);
    chk("aeoi.dv_off", 32'(data_valid), 32'h0);
    tick;
    chk("mask.int_out", 32'(int_out), 32'h0);
    irq = 8'h00;
    tick;
    chk("edge.irr_fall", 32'(irr), 32'h00);

    // Asynchronous reset in the middle of ACK2.
    mask = 8'h00;
    irq  = 8'h08;
    repeat (2) tick;
    inta_n = 1'b0;
    tick;
    inta_n = 1'b1;
    tick;
    inta_n = 1'b0;
    tick;
    chk("ack2.dv", 32'(data_valid), 32'h1);
    chk("ack2.vec", 32'(data_out), 32'h43);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    inta_n    = 1'b1;
    irq       = 8'h00;
    edge_mode = 1'b0;
    auto_eoi  = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    chk_out("post_rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

`ifdef PIC_AUTO_ROTATE_EN
    auto_eoi = 1'b1;
    irq      = 8'h04;
    repeat (2) tick;
    for (int p = 0; p < 2; p++) begin
      inta_n = 1'b0;
      tick;
      inta_n = 1'b1;
      tick;
    end
    chk("rot.ptr", 32'(dut.rot_ptr), 32'd2);
    irq = 8'h0A;
    tick;
    poll_req = 1'b1;
    tick;
    poll_req = 1'b0;
    chk("rot.poll", 32'(data_out), 32'h83);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
